// File: rtl/burst_dma_pkg.sv
// Shared types and defaults for the burst DMA controller and its bus interface.
package burst_dma_pkg;

    localparam int DEF_ADDR_STEP     = 8;
    localparam int DEF_RD_FIFO_DEPTH = 4;
    localparam int ADDR_W            = 64;
    localparam int DATA_W            = 64;
    localparam int LEN_W             = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_DRAIN
    } dma_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } dma_cmd_t;

endpackage

// File: rtl/burst_dma_if.sv
// Command, write-data, read-data and memory-port signals of the burst DMA.
interface burst_dma_if;
    import burst_dma_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    // The DMA engine side.
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_valid, mem_rdata
    );

    // The client plus memory side.
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_valid, mem_rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; DEPTH must be a power of two.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a push when the same cycle pops.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/burst_dma_ctrl.sv
// Burst DMA: streams write bursts to memory at 1 word/cycle and returns read
// bursts through a small FIFO, throttling issue so returning data always fits.
module burst_dma_ctrl
    import burst_dma_pkg::*;
#(
    parameter int ADDR_STEP     = DEF_ADDR_STEP,
    parameter int RD_FIFO_DEPTH = DEF_RD_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    burst_dma_if.slave  bus,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

    dma_state_e        state_q;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q;
    logic              done_q;
    logic              err_q;
    logic              fresh_q;

    dma_cmd_t          cmd;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              issue;
    logic              rd_issue;
    logic              push;
    logic              pop;
    logic              last_beat;

    assign cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, len: bus.cmd_len};

    assign cur_addr_d  = cur_addr_q + ADDR_W'(ADDR_STEP);
    assign remaining_d = remaining_q - LEN_W'(1);

    always_comb begin
        issue    = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            ST_WR: issue = bus.wr_valid;
            ST_RD: begin
                // A slot is reserved for the word already on its way back.
                rd_issue = (remaining_q != '0) && !fifo_full &&
                           ((fifo_count + CW'(inflight_q)) < CW'(RD_FIFO_DEPTH));
                issue    = rd_issue;
            end
            default: ;
        endcase
    end

    assign push      = bus.mem_valid && inflight_q;
    assign pop       = !fifo_empty && bus.rd_ready;
    assign last_beat = (state_q == ST_RD_DRAIN) && !inflight_q &&
                       (fifo_count == CW'(1)) && pop;

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.wr_ready  = (state_q == ST_WR);
    assign bus.mem_req   = issue;
    assign bus.mem_we    = (state_q == ST_WR);
    assign bus.mem_addr  = cur_addr_q;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.rd_valid  = !fifo_empty;
    assign bus.rd_data   = fifo_dout;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q || last_beat;
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fresh_q     <= 1'b1;
        end else begin
            fresh_q    <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= rd_issue;
            // A read cut short by reset may still answer in the first cycle out of it.
            if (bus.mem_valid && !inflight_q && !fresh_q) err_q <= 1'b1;
            if (issue) begin
                cur_addr_q  <= cur_addr_d;
                remaining_q <= remaining_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd.len != '0) begin
                            cur_addr_q  <= cmd.addr;
                            remaining_q <= cmd.len;
                            state_q     <= cmd.write ? ST_WR : ST_RD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (issue && remaining_q == LEN_W'(1)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (rd_issue && remaining_q == LEN_W'(1)) state_q <= ST_RD_DRAIN;
                end
                ST_RD_DRAIN: begin
                    if (last_beat) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (bus.mem_rdata),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_burst_dma_ctrl.sv
// Scoreboard bench for burst_dma_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_burst_dma_ctrl;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wexp_t;

    logic clk;
    logic rst;
    logic busy, done, err;

    burst_dma_if bus ();

    burst_dma_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    wexp_t       exp_wr_q[$];
    logic [63:0] exp_rdaddr_q[$];
    logic [63:0] exp_beat_q[$];
    int          exp_done_q[$];   // 0 write, 1 read, 2 zero-length
    int          wr_cyc_q[$];
    int          rdreq_cyc_q[$];
    int          beat_cyc_q[$];

    int cyc = 0;
    int acc_cyc = 0;
    int last_wr_cyc = 0;
    int last_pop_cyc = 0;
    int beats_got = 0;
    int done_seen = 0;
    int rd_issue_cnt = 0;
    int hold_issued = 0;
    int mon_kind;
    int mon_exp_cyc;
    wexp_t mon_we;
    logic [63:0] mon_val;
    logic spur = 1'b0;
    logic cap;
    logic [63:0] capa;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by reads: a fixed scramble of the address.
    function automatic logic [63:0] hashf(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h5A5A_0F0F_3C3C_A5A5;
    endfunction

    // Memory responder: answers each read request one cycle later.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            cap  = bus.mem_req && !bus.mem_we;
            capa = bus.mem_addr;
            @(posedge clk);
            #1;
            bus.mem_valid = cap || spur;
            bus.mem_rdata = cap ? hashf(capa) : 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            chk("ready_vs_busy", 64'(bus.cmd_ready), 64'(!busy));
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (bus.mem_req && bus.mem_we) begin
                if (exp_wr_q.size() == 0) chk("unexpected_mem_write", 64'd1, 64'd0);
                else begin
                    mon_we = exp_wr_q.pop_front();
                    chk("wr_addr", bus.mem_addr, mon_we.addr);
                    chk("wr_data", bus.mem_wdata, mon_we.data);
                end
                last_wr_cyc = cyc;
                wr_cyc_q.push_back(cyc);
            end
            if (bus.mem_req && !bus.mem_we) begin
                if (exp_rdaddr_q.size() == 0) chk("unexpected_mem_read", 64'd1, 64'd0);
                else begin
                    mon_val = exp_rdaddr_q.pop_front();
                    chk("rd_req_addr", bus.mem_addr, mon_val);
                end
                rd_issue_cnt++;
                rdreq_cyc_q.push_back(cyc);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_beat_q.size() == 0) chk("unexpected_rd_beat", 64'd1, 64'd0);
                else begin
                    mon_val = exp_beat_q.pop_front();
                    chk("rd_data", bus.rd_data, mon_val);
                end
                beats_got++;
                last_pop_cyc = cyc;
                beat_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    mon_kind = exp_done_q.pop_front();
                    case (mon_kind)
                        0:       mon_exp_cyc = last_wr_cyc + 1;
                        1:       mon_exp_cyc = last_pop_cyc;
                        default: mon_exp_cyc = acc_cyc + 1;
                    endcase
                    chk("done_timing", 64'(cyc), 64'(mon_exp_cyc));
                end
            end
        end
    end

    task automatic run_cmd(input bit wr, input logic [63:0] addr, input int len,
                           input int vpct, input int hold);
        logic [63:0] d[$];
        logic [63:0] dd, a;
        int tgt_done, tgt_beats, n, idx, base;
        bit acc, took;
        tgt_done  = done_seen + 1;
        tgt_beats = beats_got + (wr ? 0 : len);
        base      = rd_issue_cnt;
        if (len == 0) exp_done_q.push_back(2);
        else if (wr) begin
            for (int i = 0; i < len; i++) begin
                dd = {$urandom, $urandom};
                d.push_back(dd);
                exp_wr_q.push_back('{addr: addr + 64'(i) * 64'd8, data: dd});
            end
            exp_done_q.push_back(0);
        end else begin
            for (int i = 0; i < len; i++) begin
                a = addr + 64'(i) * 64'd8;
                exp_rdaddr_q.push_back(a);
                exp_beat_q.push_back(hashf(a));
            end
            exp_done_q.push_back(1);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 16'(len);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accept", 64'(acc), 64'd1);
        if (wr && len > 0) begin
            idx = 0;
            n = 0;
            while (idx < len && n < 500) begin
                bus.wr_valid = ($urandom_range(99) < vpct);
                bus.wr_data  = d[idx];
                @(negedge clk);
                took = bus.wr_valid && bus.wr_ready;
                @(posedge clk);
                #1;
                if (took) idx++;
                n++;
            end
            bus.wr_valid = 1'b0;
            chk("wr_beats_sent", 64'(idx), 64'(len));
        end
        if (!wr && len > 0) begin
            bus.rd_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            hold_issued = rd_issue_cnt - base;
            n = 0;
            while (beats_got < tgt_beats && n < 500) begin
                bus.rd_ready = ($urandom_range(99) < vpct);
                @(posedge clk);
                #1;
                n++;
            end
            bus.rd_ready = 1'b0;
            chk("rd_beats_rcvd", 64'(beats_got), 64'(tgt_beats));
        end
        n = 0;
        while (done_seen < tgt_done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_seen), 64'(tgt_done));
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        @(posedge clk);
        #1;

        // Write burst, data always available.
        wr_cyc_q.delete();
        run_cmd(1'b1, 64'h1000, 4, 100, 0);
        chk("wr_burst_beats", 64'(wr_cyc_q.size()), 64'd4);
        chk("wr_burst_span", 64'(wr_cyc_q[$] - wr_cyc_q[0]), 64'd3);

        // Read burst, consumer always ready.
        rdreq_cyc_q.delete();
        beat_cyc_q.delete();
        run_cmd(1'b0, 64'h2000, 8, 100, 0);
        chk("rd_first_latency", 64'(beat_cyc_q[0] - rdreq_cyc_q[0]), 64'd2);
        chk("rd_beat_span", 64'(beat_cyc_q[$] - beat_cyc_q[0]), 64'd7);
        chk("rd_beat_count", 64'(beat_cyc_q.size()), 64'd8);

        // Read burst with consumer stalled for 10 cycles.
        run_cmd(1'b0, 64'h2400, 8, 100, 10);
        chk("stall_issued", 64'(hold_issued), 64'd4);

        // Zero-length command and address wrap.
        run_cmd(1'b1, 64'h5000, 0, 100, 0);
        run_cmd(1'b0, 64'h5000, 0, 100, 0);
        run_cmd(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2, 100, 0);
        run_cmd(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2, 100, 0);

        for (int k = 0; k < 14; k++) begin
            run_cmd(1'($urandom_range(1)), {$urandom, $urandom} & ~64'h7,
                    int'($urandom_range(8)), 30 + int'($urandom_range(70)), 0);
            wait_cycles(int'($urandom_range(2)));
        end
        chk("err_clean", 64'(err), 64'd0);

        // Spurious memory return while idle.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("spurious_err", 64'(err), 64'd1);
        @(posedge clk);
        #1;
        run_cmd(1'b1, 64'h6000, 2, 100, 0);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a stalled read with two beats buffered.
        exp_rdaddr_q.push_back(64'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 64'h3000;
        bus.cmd_len   = 16'd8;
        bus.rd_ready  = 1'b0;
        exp_rdaddr_q.delete();
        for (int i = 0; i < 8; i++) exp_rdaddr_q.push_back(64'h3000 + 64'(i) * 64'd8);
        @(negedge clk);
        chk("mid_rst_accept", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_rdaddr_q.delete();
        exp_beat_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("mid_rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("post_rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        run_cmd(1'b0, 64'h4000, 3, 100, 0);

        wait_cycles(2);
        chk("left_wr", 64'(exp_wr_q.size()), 64'd0);
        chk("left_rdaddr", 64'(exp_rdaddr_q.size()), 64'd0);
        chk("left_beats", 64'(exp_beat_q.size()), 64'd0);
        chk("left_done", 64'(exp_done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_dma_ctrl.md
BURST_DMA_CTRL -- requirements
Module: burst_dma_ctrl

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 8, meaning the address increment per 64-bit word (byte addressing).
REQ-002 SHALL have parameter RD_FIFO_DEPTH, default 4, meaning read-return FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-007 SHALL have port cmd_write, input, 1, 1=write burst, 0=read burst.
REQ-008 SHALL have port cmd_addr, input, 64, burst base address.
REQ-009 SHALL have port cmd_len, input, 16, burst length in words.
REQ-010 SHALL have ports wr_valid (input, 1), wr_ready (output, 1) and wr_data (input, 64), forming the write-data stream.
REQ-011 SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_data (output, 64), forming the read-data stream.
REQ-012 SHALL have ports mem_req, mem_we, mem_addr[63:0] and mem_wdata[63:0] as outputs to the memory port.
REQ-013 SHALL have ports mem_valid (input, 1) and mem_rdata (input, 64); mem_valid and mem_rdata return exactly 1 cycle after a read request, and writes never return mem_valid.
REQ-014 SHALL have outputs busy (1, high whenever the state is not IDLE), done (1, one-cycle pulse) and err (1, sticky).

Function
REQ-015 SHALL implement the states IDLE, WR, RD and RD_DRAIN.
REQ-016 SHALL, in IDLE on cmd_valid with cmd_len>0, latch cur_addr=cmd_addr and remaining=cmd_len, then enter WR if cmd_write=1, else RD.
REQ-017 SHALL, on a command with cmd_len=0, accept the command, stay in IDLE, pulse done the next cycle and issue no mem_req.
REQ-018 SHALL drive wr_ready=1 only in WR, and make mem_req, mem_we, mem_addr and mem_wdata combinational from the registered state and cur_addr.
REQ-019 SHALL, in WR, assert mem_req=mem_we=1 with mem_addr=cur_addr and mem_wdata=wr_data in every cycle with wr_valid=1, sustaining 1 word/cycle.
REQ-020 SHALL advance cur_addr by ADDR_STEP modulo 2^64 (wrap permitted) and decrement remaining on each issued request.
REQ-021 SHALL, on the last write issue, return to IDLE and pulse done in the following cycle.
REQ-022 SHALL, in RD, issue mem_req=1 with mem_we=0 when remaining>0 and fifo_count+inflight<RD_FIFO_DEPTH; inflight is a 1-bit register set on each read issue.
REQ-023 SHALL write mem_rdata into the FIFO on mem_valid when inflight=1, making it visible on rd_valid the next cycle; rd_data is the FIFO head.
REQ-024 SHALL pop the FIFO on rd_valid&&rd_ready, allowing a push and a pop in the same cycle with the count unchanged.
REQ-025 SHALL sustain 1 read/cycle with rd_ready held high, and stall issue when rd_ready=0 without ever dropping data.
REQ-026 SHALL enter RD_DRAIN after the last read issue, and in RD_DRAIN return to IDLE and pulse done in the cycle the final beat is popped.
REQ-027 SHALL ignore mem_valid with inflight=0 and set err, except in the first cycle after rst deasserts.
REQ-028 SHALL hold cmd_ready low in every state other than IDLE.

Reset
REQ-029 SHALL, on rst, set the state to IDLE and clear remaining, inflight and the FIFO pointers/count.
REQ-030 SHALL, on rst, drive done=0, err=0, busy=0, mem_req=0, rd_valid=0 and wr_ready=0, with cmd_ready=1 from the first cycle after reset.
REQ-031 SHALL abort any burst on a mid-burst reset, losing in-flight data and issuing no further mem_req.

Structure
REQ-032 SHALL take the state enum and the default values of ADDR_STEP and RD_FIFO_DEPTH from a shared package burst_dma_pkg.
REQ-033 SHALL implement the read-return buffer as a separate sub-module sync_fifo (parameterised width and depth, exposing count, full and empty).

Verification
REQ-034 SHALL cover: write burst addr=0x1000, len=4, wr_valid held high -> mem_we pulses on 4 consecutive cycles at 0x1000/0x1008/0x1010/0x1018, done 1 cycle after the last.
REQ-035 SHALL cover: read burst addr=0x2000, len=8, rd_ready=1 -> 8 beats in address order, first rd_valid 2 cycles after the first mem_req, 1 beat/cycle.
REQ-036 SHALL cover: read len=8 with rd_ready=0 for 10 cycles -> exactly 4 mem_req issued and then stalled, no data loss, all 8 beats delivered after release.
REQ-037 SHALL cover: cmd_len=0 -> no mem_req and a done pulse 1 cycle after acceptance; addr=0xFFFF_FFFF_FFFF_FFF8, len=2 -> second address 0x0.
REQ-038 SHALL cover: rst asserted mid-read with 2 beats in the FIFO -> rd_valid=0 and cmd_ready=1 after reset, err=0.
REQ-039 SHALL cover: a spurious mem_valid while IDLE -> err=1 and held until rst.
